fetch_pc_gen: RTL and testbench
===============================

# fetch_pc_gen

Parametrised program-counter generator for the instruction-fetch stage: the next generation of the core's PC register. It holds the current fetch address, offers it to instruction memory with a valid/ready handshake, and advances sequentially. It accepts three prioritised redirect sources (trap, resolved branch/jump, decode prediction), checks target alignment, and tags every fetch with an epoch so downstream stages can drop wrong-path instructions.

## Interface
Parameters:
- XLEN, 32, address width in bits
- RESET_VECTOR, 32'h0000_0000, PC value loaded by reset (XLEN bits)
- STEP, 4, sequential increment in bytes
- ALIGN_BITS, 2, low PC bits that must be zero; 0 disables the check
- EPOCH_W, 2, epoch counter width

Ports:
- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- hold  in  1  pipeline stall; blocks sequential advance and prediction
- trap_valid  in  1  trap/exception redirect request (highest priority)
- trap_vect  in  XLEN  trap target
- redir_valid  in  1  resolved branch/jump redirect (middle priority)
- redir_vect  in  XLEN  resolved target
- pred_valid  in  1  decode-stage predicted target (lowest priority)
- pred_vect  in  XLEN  predicted target
- fetch_ready  in  1  instruction memory accepts the current address
- fetch_valid  out  1  pc is a valid fetch request
- pc  out  XLEN  current fetch address
- epoch  out  EPOCH_W  path tag of current pc
- misalign_fault  out  1  pc is misaligned; fetch suspended

## Operation
- States: BOOT, RUN, FAULT.
- Reset: pc=RESET_VECTOR, epoch=0, state=BOOT, fetch_valid=0, misalign_fault=0. rst overrides every other input on any cycle, in any state.
- BOOT: lasts exactly one cycle. fetch_valid=0. Next state is RUN. A trap/redir in BOOT is applied per the rules below.
- RUN: fetch_valid=1. A handshake occurs when fetch_valid & fetch_ready.
- FAULT: fetch_valid=0 and misalign_fault=1. Only trap_valid or rst leaves FAULT. redir and pred are ignored.
- Next-pc priority, evaluated every cycle:
  - trap_valid: pc<=trap_vect and epoch<=epoch+1. Hold and handshake are ignored.
  - else redir_valid: pc<=redir_vect and epoch<=epoch+1. Hold and handshake are ignored. Ignored in FAULT.
  - else handshake & ~hold & pred_valid: pc<=pred_vect. Epoch is unchanged.
  - else handshake & ~hold: pc<=pc+STEP.
  - else pc holds.
- A trap and a redir in the same cycle give trap_vect and a single epoch increment.
- Alignment: any loaded target whose bits [ALIGN_BITS-1:0] are nonzero is still loaded into pc. The next state becomes FAULT.
  - An aligned trap target moves the block to RUN. This applies from FAULT and from BOOT.
  - A misaligned trap target moves the block to FAULT, or keeps it there.
- Arithmetic: pc+STEP is computed modulo 2^XLEN; for example, 32'hFFFF_FFFC+4 wraps to 0. Epoch also wraps modulo 2^EPOCH_W.
- When ALIGN_BITS=0, FAULT is unreachable.

## Timing
- All outputs are registered with no combinational input-to-output path.
- Redirect latency is one cycle: a request sampled at edge N gives pc=target at N+1. fetch_valid=1 at N+1 if the target is aligned and the state is not FAULT.
- Sequential latency is one cycle: a handshake at edge N gives pc+STEP at N+1.
- A handshake completes only while hold=0. While hold=1, pc and fetch_valid are stable.
- Downstream must not treat an address as accepted while hold=1.
- After rst deasserts: first cycle is BOOT (fetch_valid=0), then RUN at RESET_VECTOR with epoch=0.
- Reset asserted mid-handshake discards the in-flight address. The next pc is RESET_VECTOR.

## Structure
- Shared package fetch_pkg contains:
  - state enum: BOOT, RUN, FAULT
  - default STEP and ALIGN_BITS constants, which are shared with the decode and branch units
- Single module with no sub-modules. The priority mux, alignment check and epoch counter are all local logic.

## Test plan
- Reset then fetch_ready=1, hold=0: pc goes 0 (fetch_valid=0 in BOOT), 0, 4, 8, 12; epoch=0 throughout.
- Stall: hold=1 for 3 cycles at pc=0x10 -> pc stays 0x10 and fetch_valid stays 1; on release, pc=0x14 the next cycle.
- Priority: trap_vect=0x100, redir_vect=0x200 and pred_vect=0x300 in the same cycle -> pc=0x100 and epoch increments by exactly 1.
  - Same cycle, redir_vect=0x200 and pred_vect=0x300 only -> pc=0x200.
- Redirect during hold: hold=1 with redir_vect=0x40 -> pc=0x40 the next cycle and epoch+1.
  - hold=1 with pred_valid only -> pc unchanged.
- Misalign: redir_vect=0x22 -> pc=0x22, misalign_fault=1, fetch_valid=0.
  - A following redir is ignored; trap_vect=0x80 -> RUN, pc=0x80, fault clears.
- Wrap and reset: pc=0xFFFF_FFFC, then handshake -> pc=0, epoch unchanged.
  - Asserting rst on that cycle instead -> pc=RESET_VECTOR, epoch=0, BOOT.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: definitions shared by the fetch, decode and branch units.
//   fetch_state_e      - fetch PC generator state (BOOT, RUN, FAULT)
//   DEFAULT_STEP       - default sequential fetch increment in bytes
//   DEFAULT_ALIGN_BITS - default count of low PC bits that must be zero
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } fetch_state_e;

  localparam int DEFAULT_STEP       = 4;
  localparam int DEFAULT_ALIGN_BITS = 2;

endpackage

// File: rtl/fetch_pc_gen.sv
// fetch_pc_gen: program-counter generator for the instruction-fetch stage.
// Holds the current fetch address and offers it to instruction memory with a
// valid/ready handshake. The address advances sequentially, or is redirected by
// a trap, a resolved branch or a decode prediction. Every redirect bumps the
// epoch so downstream stages can drop wrong-path instructions.
//
// Ports:
//   clk, rst        - clock and synchronous active-high reset
//   hold            - stall; blocks sequential advance and prediction
//   trap_valid/vect - trap redirect (highest priority, also leaves FAULT)
//   redir_valid/vect- resolved branch/jump redirect (ignored in FAULT)
//   pred_valid/vect - predicted target, taken only on an unstalled handshake
//   fetch_ready     - instruction memory accepts pc this cycle
//   fetch_valid     - pc is a valid fetch request (RUN state)
//   pc, epoch       - current fetch address and its path tag
//   misalign_fault  - pc is misaligned and fetch is suspended
module fetch_pc_gen
  import fetch_pkg::*;
#(
  parameter int               XLEN         = 32,
  parameter logic [XLEN-1:0]  RESET_VECTOR = '0,
  parameter int               STEP         = DEFAULT_STEP,
  parameter int               ALIGN_BITS   = DEFAULT_ALIGN_BITS,
  parameter int               EPOCH_W      = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               hold,
  input  logic               trap_valid,
  input  logic [XLEN-1:0]    trap_vect,
  input  logic               redir_valid,
  input  logic [XLEN-1:0]    redir_vect,
  input  logic               pred_valid,
  input  logic [XLEN-1:0]    pred_vect,
  input  logic               fetch_ready,
  output logic               fetch_valid,
  output logic [XLEN-1:0]    pc,
  output logic [EPOCH_W-1:0] epoch,
  output logic               misalign_fault
);

  // Mask of the low bits that must be zero; shifting by XLEN yields an
  // all-zero mask, which disables the check when ALIGN_BITS is 0.
  localparam logic [XLEN-1:0] ALIGN_MASK = {XLEN{1'b1}} >> (XLEN - ALIGN_BITS);
  localparam logic [XLEN-1:0] STEP_INC   = XLEN'(STEP);

  fetch_state_e       state_q, state_d;
  logic [XLEN-1:0]    pc_q, pc_d;
  logic [EPOCH_W-1:0] epoch_q, epoch_d;
  logic               fetch_valid_q, fetch_valid_d;
  logic               misalign_fault_q, misalign_fault_d;
  logic               handshake;
  logic               load;

  // fetch_valid_q is high only in RUN, so an accepted handshake implies RUN.
  assign handshake = fetch_valid_q & fetch_ready & ~hold;

  always_comb begin
    pc_d             = pc_q;
    epoch_d          = epoch_q;
    state_d          = state_q;
    load             = 1'b0;
    fetch_valid_d    = 1'b0;
    misalign_fault_d = 1'b0;

    if (trap_valid) begin
      pc_d    = trap_vect;
      epoch_d = epoch_q + EPOCH_W'(1);
      load    = 1'b1;
    end else if (redir_valid && state_q != FAULT) begin
      pc_d    = redir_vect;
      epoch_d = epoch_q + EPOCH_W'(1);
      load    = 1'b1;
    end else if (handshake) begin
      pc_d = pred_valid ? pred_vect : pc_q + STEP_INC;
      load = 1'b1;
    end

    case (state_q)
      BOOT:    state_d = RUN;
      RUN:     state_d = RUN;
      FAULT:   state_d = FAULT;
      default: state_d = BOOT;
    endcase

    // Any newly loaded address decides the state: misaligned targets are
    // still loaded but suspend fetch until an aligned trap arrives.
    if (load) begin
      state_d = ((pc_d & ALIGN_MASK) != '0) ? FAULT : RUN;
    end

    fetch_valid_d    = (state_d == RUN);
    misalign_fault_d = (state_d == FAULT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= BOOT;
      pc_q             <= RESET_VECTOR;
      epoch_q          <= '0;
      fetch_valid_q    <= 1'b0;
      misalign_fault_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      pc_q             <= pc_d;
      epoch_q          <= epoch_d;
      fetch_valid_q    <= fetch_valid_d;
      misalign_fault_q <= misalign_fault_d;
    end
  end

  assign fetch_valid    = fetch_valid_q;
  assign pc             = pc_q;
  assign epoch          = epoch_q;
  assign misalign_fault = misalign_fault_q;

endmodule

// File: tb/tb_fetch_pc_gen.sv
// tb_fetch_pc_gen: directed scoreboard bench for fetch_pc_gen.
// Each cycle the stimulus is driven together with the expected post-edge
// outputs, which are queued and then popped and compared after the edge.
module tb_fetch_pc_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hold = 1'b0;
  logic        trap_valid = 1'b0;
  logic [31:0] trap_vect = '0;
  logic        redir_valid = 1'b0;
  logic [31:0] redir_vect = '0;
  logic        pred_valid = 1'b0;
  logic [31:0] pred_vect = '0;
  logic        fetch_ready = 1'b0;
  logic        fetch_valid;
  logic [31:0] pc;
  logic [1:0]  epoch;
  logic        misalign_fault;

  typedef struct packed {
    logic [31:0] pc;
    logic [1:0]  epoch;
    logic        fv;
    logic        fault;
  } exp_t;

  exp_t exp_q[$];
  int   checks_total  = 0;
  int   checks_passed = 0;
  int   cyc = 0;

  fetch_pc_gen dut (
    .clk            (clk),
    .rst            (rst),
    .hold           (hold),
    .trap_valid     (trap_valid),
    .trap_vect      (trap_vect),
    .redir_valid    (redir_valid),
    .redir_vect     (redir_vect),
    .pred_valid     (pred_valid),
    .pred_vect      (pred_vect),
    .fetch_ready    (fetch_ready),
    .fetch_valid    (fetch_valid),
    .pc             (pc),
    .epoch          (epoch),
    .misalign_fault (misalign_fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks_total++;
    if (obs === expv) checks_passed++;
    else $display("FAIL cyc%0d %s: got 0x%08h expected 0x%08h", cyc, tag, obs, expv);
  endtask

  task automatic clr();
    rst = 1'b0; hold = 1'b0;
    trap_valid = 1'b0; redir_valid = 1'b0; pred_valid = 1'b0;
  endtask

  // Inputs are already set by the caller; push expectation, clock, compare.
  task automatic run_cycle(input logic [31:0] e_pc, input logic [1:0] e_ep,
                           input logic e_fv, input logic e_fault);
    exp_t e;
    exp_q.push_back('{pc: e_pc, epoch: e_ep, fv: e_fv, fault: e_fault});
    @(posedge clk);
    #1;
    cyc++;
    e = exp_q.pop_front();
    check("pc", pc, e.pc);
    check("epoch", 32'(epoch), 32'(e.epoch));
    check("fetch_valid", 32'(fetch_valid), 32'(e.fv));
    check("misalign_fault", 32'(misalign_fault), 32'(e.fault));
    $display("cyc%0d pc=0x%08h epoch=%0d fv=%0b fault=%0b", cyc, pc, epoch,
             fetch_valid, misalign_fault);
  endtask

  initial begin
    #1;
    // Reset, then sequential fetch.
    rst = 1'b1; fetch_ready = 1'b1;
    run_cycle(32'h0, 2'd0, 1'b0, 1'b0);          // reset -> BOOT
    clr();
    run_cycle(32'h0, 2'd0, 1'b1, 1'b0);          // BOOT -> RUN at 0
    run_cycle(32'h4, 2'd0, 1'b1, 1'b0);
    run_cycle(32'h8, 2'd0, 1'b1, 1'b0);
    run_cycle(32'hC, 2'd0, 1'b1, 1'b0);
    run_cycle(32'h10, 2'd0, 1'b1, 1'b0);

    // Stall at 0x10 for three cycles, then release.
    hold = 1'b1;
    for (int i = 0; i < 3; i++) run_cycle(32'h10, 2'd0, 1'b1, 1'b0);
    hold = 1'b0;
    run_cycle(32'h14, 2'd0, 1'b1, 1'b0);

    // Priority: trap beats redir beats pred, one epoch bump.
    trap_valid = 1'b1; trap_vect = 32'h100;
    redir_valid = 1'b1; redir_vect = 32'h200;
    pred_valid = 1'b1; pred_vect = 32'h300;
    run_cycle(32'h100, 2'd1, 1'b1, 1'b0);
    trap_valid = 1'b0;
    run_cycle(32'h200, 2'd2, 1'b1, 1'b0);

    // Redirect during hold is taken; prediction during hold is not.
    clr(); hold = 1'b1; redir_valid = 1'b1; redir_vect = 32'h40;
    run_cycle(32'h40, 2'd3, 1'b1, 1'b0);
    clr(); hold = 1'b1; pred_valid = 1'b1; pred_vect = 32'h300;
    run_cycle(32'h40, 2'd3, 1'b1, 1'b0);
    // Unstalled prediction is taken without an epoch change.
    hold = 1'b0;
    run_cycle(32'h300, 2'd3, 1'b1, 1'b0);
    // No ready, no handshake: pc holds.
    clr(); fetch_ready = 1'b0;
    run_cycle(32'h300, 2'd3, 1'b1, 1'b0);
    fetch_ready = 1'b1;

    // Misaligned redirect -> FAULT, epoch wraps 3 -> 0.
    redir_valid = 1'b1; redir_vect = 32'h22;
    run_cycle(32'h22, 2'd0, 1'b0, 1'b1);
    redir_vect = 32'h50; pred_valid = 1'b1; pred_vect = 32'h60;
    run_cycle(32'h22, 2'd0, 1'b0, 1'b1);         // redir/pred ignored
    clr(); trap_valid = 1'b1; trap_vect = 32'h80;
    run_cycle(32'h80, 2'd1, 1'b1, 1'b0);         // aligned trap recovers
    trap_vect = 32'h81;
    run_cycle(32'h81, 2'd2, 1'b0, 1'b1);         // misaligned trap from RUN
    trap_vect = 32'h82;
    run_cycle(32'h82, 2'd3, 1'b0, 1'b1);         // misaligned trap stays FAULT
    trap_vect = 32'h84;
    run_cycle(32'h84, 2'd0, 1'b1, 1'b0);

    // Wrap at the top of the address space.
    trap_vect = 32'hFFFF_FFFC;
    run_cycle(32'hFFFF_FFFC, 2'd1, 1'b1, 1'b0);
    clr();
    run_cycle(32'h0, 2'd1, 1'b1, 1'b0);

    // Same setup, but reset on the handshake cycle.
    trap_valid = 1'b1; trap_vect = 32'hFFFF_FFFC;
    run_cycle(32'hFFFF_FFFC, 2'd2, 1'b1, 1'b0);
    clr(); rst = 1'b1; trap_valid = 1'b1; trap_vect = 32'h200;
    run_cycle(32'h0, 2'd0, 1'b0, 1'b0);          // rst overrides trap

    // Redirect applied in BOOT.
    clr(); redir_valid = 1'b1; redir_vect = 32'h60;
    run_cycle(32'h60, 2'd1, 1'b1, 1'b0);
    clr();
    run_cycle(32'h64, 2'd1, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
